// File: rtl/char_state_pkg.sv
// char_state_pkg
// Shared definitions for the character action FSM and the position handler:
// state encodings, state/phase widths and small decode helpers.
package char_state_pkg;

   localparam int STATE_W = 4;
   localparam int PHASE_W = 5;

   localparam logic [STATE_W-1:0] S_IDLE                = 4'b0000;
   localparam logic [STATE_W-1:0] S_LEFT                = 4'b0001;
   localparam logic [STATE_W-1:0] S_RIGHT               = 4'b0010;
   localparam logic [STATE_W-1:0] S_ATTACK_START        = 4'b0011;
   localparam logic [STATE_W-1:0] S_ATTACK_ACTIVE       = 4'b0100;
   localparam logic [STATE_W-1:0] S_ATTACK_RECOVERY     = 4'b0101;
   localparam logic [STATE_W-1:0] S_ATTACK_DIR_START    = 4'b0110;
   localparam logic [STATE_W-1:0] S_ATTACK_DIR_ACTIVE   = 4'b0111;
   localparam logic [STATE_W-1:0] S_ATTACK_DIR_RECOVERY = 4'b1000;

   // Any of the six attack codes (0011..1000).
   function automatic logic is_attack(input logic [STATE_W-1:0] s);
      return (s >= S_ATTACK_START) && (s <= S_ATTACK_DIR_RECOVERY);
   endfunction

   // Hit frames of either attack flavour.
   function automatic logic is_active(input logic [STATE_W-1:0] s);
      return (s == S_ATTACK_ACTIVE) || (s == S_ATTACK_DIR_ACTIVE);
   endfunction

endpackage

// File: rtl/char_state_handler_if.sv
// char_state_handler_if
// Per-player bundle between the button front end and the character FSM.
//   btn_left/btn_right/btn_attack : synchronised, debounced buttons
//   state/phase_cnt/attack_active/busy : registered FSM outputs
// master = button source / consumer side, slave = the FSM.
interface char_state_handler_if;
   import char_state_pkg::*;

   logic               btn_left;
   logic               btn_right;
   logic               btn_attack;
   logic [STATE_W-1:0] state;
   logic [PHASE_W-1:0] phase_cnt;
   logic               attack_active;
   logic               busy;

   modport master (
      output btn_left, btn_right, btn_attack,
      input  state, phase_cnt, attack_active, busy
   );

   modport slave (
      input  btn_left, btn_right, btn_attack,
      output state, phase_cnt, attack_active, busy
   );

endinterface

// File: rtl/rise_detect.sv
// rise_detect
// Rising-edge detector for a synchronous level input.
//   clk, rst : clock and synchronous active-high reset
//   d        : level input
//   rise     : d is high now and was low on the previous cycle
// RESET_VAL sets the remembered previous value after reset; a value of 1
// suppresses a "rise" from an input that was already held through reset.
module rise_detect #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic d_q_r;

   // Remember the previous sample of d.
   always_ff @(posedge clk) begin
      if (rst) begin
         d_q_r <= RESET_VAL;
      end else begin
         d_q_r <= d;
      end
   end

   assign rise = d & ~d_q_r;

endmodule

// File: rtl/char_state_handler.sv
// char_state_handler
// Per-player action FSM: turns buttons into the 4-bit character state used by
// the position handler and sprite/hitbox logic. One clk cycle = one frame.
//   clk, rst : frame clock, synchronous active-high reset
//   bus      : slave side of char_state_handler_if (buttons in, state,
//              phase_cnt, attack_active, busy out; all outputs registered)
module char_state_handler
   import char_state_pkg::*;
#(
   parameter int ATK_START_FRAMES    = 5,
   parameter int ATK_ACTIVE_FRAMES   = 2,
   parameter int ATK_RECOVERY_FRAMES = 16,
   parameter int DIR_START_FRAMES    = 4,
   parameter int DIR_ACTIVE_FRAMES   = 3,
   parameter int DIR_RECOVERY_FRAMES = 15
) (
   input  logic               clk,
   input  logic               rst,
   char_state_handler_if.slave bus
);

   localparam logic [PHASE_W-1:0] ATK_START_LAST    = PHASE_W'(ATK_START_FRAMES - 1);
   localparam logic [PHASE_W-1:0] ATK_ACTIVE_LAST   = PHASE_W'(ATK_ACTIVE_FRAMES - 1);
   localparam logic [PHASE_W-1:0] ATK_RECOVERY_LAST = PHASE_W'(ATK_RECOVERY_FRAMES - 1);
   localparam logic [PHASE_W-1:0] DIR_START_LAST    = PHASE_W'(DIR_START_FRAMES - 1);
   localparam logic [PHASE_W-1:0] DIR_ACTIVE_LAST   = PHASE_W'(DIR_ACTIVE_FRAMES - 1);
   localparam logic [PHASE_W-1:0] DIR_RECOVERY_LAST = PHASE_W'(DIR_RECOVERY_FRAMES - 1);

   logic [STATE_W-1:0] state_r;
   logic [PHASE_W-1:0] phase_r;
   logic               attack_active_r;
   logic               busy_r;

   logic [STATE_W-1:0] state_nxt_s;
   logic [PHASE_W-1:0] phase_nxt_s;
   logic               attack_active_nxt_s;
   logic               busy_nxt_s;
   logic [STATE_W-1:0] move_s;
   logic               atk_rise_s;
   logic               one_dir_s;

   // Previous-attack flag resets high so a press held through reset never fires.
   rise_detect #(.RESET_VAL(1'b1)) u_atk_rise (
      .clk  (clk),
      .rst  (rst),
      .d    (bus.btn_attack),
      .rise (atk_rise_s)
   );

   assign one_dir_s = bus.btn_left ^ bus.btn_right;

   // Movement decode: exactly one direction moves, both or neither stands.
   always_comb begin
      move_s = S_IDLE;
      if (bus.btn_left && !bus.btn_right) begin
         move_s = S_LEFT;
      end else if (bus.btn_right && !bus.btn_left) begin
         move_s = S_RIGHT;
      end else begin
         move_s = S_IDLE;
      end
   end

   // Next state and phase counter; attack states ignore all buttons.
   always_comb begin
      state_nxt_s = S_IDLE;
      phase_nxt_s = '0;
      case (state_r)
         S_IDLE, S_LEFT, S_RIGHT: begin
            if (atk_rise_s) begin
               state_nxt_s = one_dir_s ? S_ATTACK_DIR_START : S_ATTACK_START;
            end else begin
               state_nxt_s = move_s;
            end
         end
         S_ATTACK_START: begin
            if (phase_r == ATK_START_LAST) begin
               state_nxt_s = S_ATTACK_ACTIVE;
            end else begin
               state_nxt_s = state_r;
               phase_nxt_s = phase_r + 5'd1;
            end
         end
         S_ATTACK_ACTIVE: begin
            if (phase_r == ATK_ACTIVE_LAST) begin
               state_nxt_s = S_ATTACK_RECOVERY;
            end else begin
               state_nxt_s = state_r;
               phase_nxt_s = phase_r + 5'd1;
            end
         end
         S_ATTACK_RECOVERY: begin
            if (phase_r == ATK_RECOVERY_LAST) begin
               state_nxt_s = move_s;
            end else begin
               state_nxt_s = state_r;
               phase_nxt_s = phase_r + 5'd1;
            end
         end
         S_ATTACK_DIR_START: begin
            if (phase_r == DIR_START_LAST) begin
               state_nxt_s = S_ATTACK_DIR_ACTIVE;
            end else begin
               state_nxt_s = state_r;
               phase_nxt_s = phase_r + 5'd1;
            end
         end
         S_ATTACK_DIR_ACTIVE: begin
            if (phase_r == DIR_ACTIVE_LAST) begin
               state_nxt_s = S_ATTACK_DIR_RECOVERY;
            end else begin
               state_nxt_s = state_r;
               phase_nxt_s = phase_r + 5'd1;
            end
         end
         S_ATTACK_DIR_RECOVERY: begin
            if (phase_r == DIR_RECOVERY_LAST) begin
               state_nxt_s = move_s;
            end else begin
               state_nxt_s = state_r;
               phase_nxt_s = phase_r + 5'd1;
            end
         end
         default: begin
            // Illegal codes fall back to standing still.
            state_nxt_s = S_IDLE;
            phase_nxt_s = '0;
         end
      endcase
   end

   // Status flags for the upcoming state, registered alongside it.
   always_comb begin
      busy_nxt_s          = is_attack(state_nxt_s);
      attack_active_nxt_s = is_active(state_nxt_s);
   end

   // State, phase counter and status flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r         <= S_IDLE;
         phase_r         <= '0;
         attack_active_r <= 1'b0;
         busy_r          <= 1'b0;
      end else begin
         state_r         <= state_nxt_s;
         phase_r         <= phase_nxt_s;
         attack_active_r <= attack_active_nxt_s;
         busy_r          <= busy_nxt_s;
      end
   end

   assign bus.state         = state_r;
   assign bus.phase_cnt     = phase_r;
   assign bus.attack_active = attack_active_r;
   assign bus.busy          = busy_r;

endmodule

// File: tb/tb_char_state_handler.sv
// tb_char_state_handler
// Directed bench for char_state_handler at default parameters. Inputs are
// driven and outputs sampled on the falling edge; frame k is what is seen
// after the k-th rising edge following a stimulus change.
module tb_char_state_handler;
   import char_state_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   char_state_handler_if bus ();

   char_state_handler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_btn(input logic l, input logic r, input logic a);
      bus.btn_left   = l;
      bus.btn_right  = r;
      bus.btn_attack = a;
   endtask

   // Runs one full attack already triggered by the current inputs.
   // pat[i] is the attack button level driven while frame i is visible.
   task automatic run_attack(input string tag, input logic dir, input logic [31:0] pat);
      int s, a, r;
      logic [STATE_W-1:0] c0, c1, c2, exp_st;
      int exp_ph;
      if (dir) begin
         s = 4; a = 3; r = 15;
         c0 = 4'b0110; c1 = 4'b0111; c2 = 4'b1000;
      end else begin
         s = 5; a = 2; r = 16;
         c0 = 4'b0011; c1 = 4'b0100; c2 = 4'b0101;
      end
      for (int i = 1; i <= s + a + r; i++) begin
         tick();
         if (i <= s) begin
            exp_st = c0; exp_ph = i - 1;
         end else if (i <= s + a) begin
            exp_st = c1; exp_ph = i - s - 1;
         end else begin
            exp_st = c2; exp_ph = i - s - a - 1;
         end
         check_val($sformatf("%s_state_f%0d", tag, i), 32'(bus.state), 32'(exp_st));
         check_val($sformatf("%s_phase_f%0d", tag, i), 32'(bus.phase_cnt), 32'(exp_ph));
         check_val($sformatf("%s_busy_f%0d", tag, i), 32'(bus.busy), 32'd1);
         check_val($sformatf("%s_act_f%0d", tag, i), 32'(bus.attack_active),
                   32'((i > s) && (i <= s + a)));
         bus.btn_attack = pat[i];
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      // Reset with attack held, then keep holding: no attack may start.
      rst = 1'b1;
      set_btn(1'b0, 1'b0, 1'b1);
      tick();
      tick();
      check_val("rst_state", 32'(bus.state), 32'd0);
      check_val("rst_phase", 32'(bus.phase_cnt), 32'd0);
      check_val("rst_busy", 32'(bus.busy), 32'd0);
      check_val("rst_act", 32'(bus.attack_active), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_val("hold_state", 32'(bus.state), 32'd0);
         check_val("hold_busy", 32'(bus.busy), 32'd0);
      end
      set_btn(1'b0, 1'b0, 1'b0);
      tick();
      check_val("release_state", 32'(bus.state), 32'd0);

      // Neutral attack, single-cycle pulse.
      bus.btn_attack = 1'b1;
      run_attack("neu", 1'b0, 32'h0000_0000);
      tick();
      check_val("neu_exit_state", 32'(bus.state), 32'd0);
      check_val("neu_exit_busy", 32'(bus.busy), 32'd0);
      check_val("neu_exit_phase", 32'(bus.phase_cnt), 32'd0);

      // Directional attack with right held throughout; attack kept held.
      set_btn(1'b0, 1'b1, 1'b0);
      tick();
      check_val("dir_pre_state", 32'(bus.state), 32'd2);
      bus.btn_attack = 1'b1;
      run_attack("dir", 1'b1, 32'hFFFF_FFFF);
      tick();
      check_val("dir_exit_state", 32'(bus.state), 32'd2);
      check_val("dir_exit_busy", 32'(bus.busy), 32'd0);
      set_btn(1'b0, 1'b0, 1'b0);
      tick();
      check_val("dir_idle", 32'(bus.state), 32'd0);

      // Lockout: held attack with re-presses in ACTIVE and in the last
      // recovery frame; neither may chain a new attack.
      bus.btn_attack = 1'b1;
      run_attack("lock", 1'b0, 32'hFFBF_FFDF);
      tick();
      check_val("lock_exit_state", 32'(bus.state), 32'd0);
      tick();
      check_val("lock_stay_state", 32'(bus.state), 32'd0);
      check_val("lock_stay_busy", 32'(bus.busy), 32'd0);
      bus.btn_attack = 1'b0;
      tick();
      bus.btn_attack = 1'b1;
      tick();
      check_val("lock_fresh_state", 32'(bus.state), 32'd3);
      // Abort via reset mid-recovery: frame 11 is RECOVERY phase 3.
      for (int i = 2; i <= 11; i++) tick();
      check_val("mid_pre_state", 32'(bus.state), 32'd5);
      check_val("mid_pre_phase", 32'(bus.phase_cnt), 32'd3);
      rst = 1'b1;
      tick();
      check_val("mid_rst_state", 32'(bus.state), 32'd0);
      check_val("mid_rst_phase", 32'(bus.phase_cnt), 32'd0);
      check_val("mid_rst_busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;
      set_btn(1'b0, 1'b0, 1'b0);
      tick();

      // Movement decode.
      set_btn(1'b1, 1'b0, 1'b0);
      tick();
      check_val("mv_left", 32'(bus.state), 32'd1);
      set_btn(1'b0, 1'b1, 1'b0);
      tick();
      check_val("mv_right", 32'(bus.state), 32'd2);
      set_btn(1'b1, 1'b1, 1'b0);
      tick();
      check_val("mv_both", 32'(bus.state), 32'd0);
      set_btn(1'b0, 1'b0, 1'b0);
      tick();
      check_val("mv_none", 32'(bus.state), 32'd0);
      set_btn(1'b1, 1'b1, 1'b1);
      tick();
      check_val("both_atk_state", 32'(bus.state), 32'd3);
      check_val("both_atk_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // Illegal code recovery: with left held, LEFT would persist, so only
      // the illegal-state path can yield IDLE here.
      set_btn(1'b1, 1'b0, 1'b0);
      tick();
      check_val("ill_pre_state", 32'(bus.state), 32'd1);
      force dut.state_r = 4'b1010;
      #1;
      release dut.state_r;
      check_val("ill_forced", 32'(bus.state), 32'hA);
      tick();
      check_val("ill_recover", 32'(bus.state), 32'd0);
      tick();
      check_val("ill_then_left", 32'(bus.state), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
